pipo_universal_shifter: RTL and testbench
=========================================

Name: pipo_universal_shifter

Overview:
- Parametrised successor to the team's load/shift-left PIPO register used by the sequential multiplier/divider datapaths.
- Adds the following to that register:
  - an independent register width;
  - zero- or sign-extending load;
  - seven shift/rotate modes with serial fill;
  - a captured shifted-out bit;
  - an autonomous N-step shift sequencer with busy/done handshake.
- Sits between operand registers and the control FSM of the arithmetic units.

Parameters:
- WORD_LENGTH, 8, width of parallelInput.
- REG_LENGTH, 16, width of the internal register and parallelOutput. Must be greater than or equal to WORD_LENGTH.
- CNT_WIDTH, 5, width of the count input. The maximum auto-run length is 2^CNT_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load parallelInput into the register.
- signExt  input  1  on load: 1 = sign-extend parallelInput, 0 = zero-extend it.
- parallelInput  input  WORD_LENGTH  load data, placed in the LSBs.
- mode  input  3  shift operation select (encoding below).
- shift  input  1  single-step shift using mode.
- start  input  1  begin an auto-run of count shifts using mode.
- count  input  CNT_WIDTH  number of shifts for an auto-run.
- serialIn  input  1  fill bit for the serial modes.
- parallelOutput  output  REG_LENGTH  register contents.
- serialOut  output  REG_LENGTH bits? No: serialOut  output  1  last bit shifted or rotated out (registered).
- busy  output  1  auto-run in progress.
- done  output  1  one-cycle pulse when an auto-run completes.

Behaviour:
- Reset: rst=1 at a rising edge sets register=0, serialOut=0, busy=0, done=0, and clears the internal remaining-count and latched mode. Reset applied mid-run aborts the run and no done pulse is produced.
- Mode encoding (R = register):
  - 000 SHL: R<<1, LSB filled with 0.
  - 001 SHR: logical right, MSB filled with 0.
  - 010 SAR: arithmetic right, MSB replicated.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101 SHL_S: left shift, LSB filled with serialIn.
  - 110 SHR_S: right shift, MSB filled with serialIn.
  - 111 HOLD: no change.
- serialOut update on each executed shift:
  - left modes (000, 011, 101): the old MSB;
  - right modes (001, 010, 100, 110): the old LSB;
  - HOLD: serialOut unchanged.
- Load: register = parallelInput extended to REG_LENGTH (sign- or zero-extended per signExt). serialOut is unchanged. done=0.
- Priority each edge, highest first: rst > load > start (only when not busy) > auto-run step (while busy) > shift (only when not busy).
- Load while busy aborts the run: busy goes to 0 and no done pulse is produced.
- Auto-run sequence:
  - start with busy=0 and count=N>0 at edge k latches N and mode. busy=1 after edge k and the register is unchanged at edge k.
  - Edges k+1 through k+N each perform one shift with the latched mode; later changes to the mode input are ignored.
  - After edge k+N: busy=0, and done=1 for exactly one cycle.
  - Latency from start to done is N+1 cycles.
- Boundary cases:
  - start with count=0: no shift, busy stays 0, done=1 for one cycle after that edge.
  - start or shift while busy: ignored.
  - start and shift together with busy=0: start wins and no single-step shift occurs.
  - A new start is accepted in the same cycle done is high, since busy=0 then. done is still high for that cycle only.
- Single step: shift=1 with busy=0 (and no load or start) performs one shift per edge. done is not asserted.
- done is 0 in every cycle not listed above.
- Rotates and shifts by a full REG_LENGTH in auto-run follow naturally from repeated single shifts. No special casing is required.

Test Plan:
- Reset/load: rst=1 -> parallelOutput=0x0000, busy=0, done=0. Then load with parallelInput=0xA5 and signExt=0 -> 0x00A5. With signExt=1 -> 0xFFA5.
- Single steps: load 0x81 (zero-extend), then shift with mode=000 for 3 cycles -> 0x0408. Then mode=010 for 1 cycle -> 0x0204, serialOut=0.
- Auto-run: load 0xF0 with signExt=1 (0xFFF0), start with count=4, mode=010 -> busy high for 4 cycles, result 0xFFFF, done pulses exactly once 5 cycles after start.
- Rotate and serial fill:
  - load 0x01, start with count=1, mode=100 -> 0x8000, serialOut=1.
  - Then mode=101 with serialIn=1 and shift for 2 cycles -> 0x0003, serialOut=0.
- Abort and ignore:
  - During a count=10 run, assert start and shift -> no effect.
  - At step 3, assert load 0x55 -> 0x0055, busy=0, no done.
  - count=0 start -> done pulse, register unchanged.
- Mid-run reset: start with count=8, assert rst at step 2 -> all outputs 0 next cycle, no done pulse ever.

Source files
------------

// File: rtl/pipo_universal_shifter.sv
// Parallel-in/parallel-out shift register with seven shift/rotate modes,
// zero/sign-extending load, and an N-step auto-run sequencer.
//
// state    | meaning
// ST_IDLE  | accepts load, start and single-step shift
// ST_RUN   | auto-run active; one shift per edge with the latched mode
module pipo_universal_shifter #(
    parameter int WORD_LENGTH = 8,
    parameter int REG_LENGTH  = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   signExt,
    input  logic [WORD_LENGTH-1:0] parallelInput,
    input  logic [2:0]             mode,
    input  logic                   shift,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   count,
    input  logic                   serialIn,
    output logic [REG_LENGTH-1:0]  parallelOutput,
    output logic                   serialOut,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        M_SHL   = 3'b000,
        M_SHR   = 3'b001,
        M_SAR   = 3'b010,
        M_ROL   = 3'b011,
        M_ROR   = 3'b100,
        M_SHL_S = 3'b101,
        M_SHR_S = 3'b110,
        M_HOLD  = 3'b111
    } mode_t;

    state_t                  state_q, state_d;
    logic [REG_LENGTH-1:0]   reg_q, reg_d;
    logic                    so_q, so_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [2:0]              mode_q, mode_d;
    logic                    done_q, done_d;

    logic [2:0]              sel_mode;
    logic [REG_LENGTH-1:0]   sh_reg;
    logic                    sh_so;
    logic [REG_LENGTH-1:0]   load_val;

    always_comb begin
        if (signExt) begin
            load_val = REG_LENGTH'($signed(parallelInput));
        end else begin
            load_val = REG_LENGTH'(parallelInput);
        end
    end

    // One shift step of the current register; mode comes from the latch while running.
    always_comb begin
        sel_mode = (state_q == ST_RUN) ? mode_q : mode;
        sh_reg   = reg_q;
        sh_so    = so_q;
        case (mode_t'(sel_mode))
            M_SHL: begin
                sh_reg = {reg_q[REG_LENGTH-2:0], 1'b0};
                sh_so  = reg_q[REG_LENGTH-1];
            end
            M_SHR: begin
                sh_reg = {1'b0, reg_q[REG_LENGTH-1:1]};
                sh_so  = reg_q[0];
            end
            M_SAR: begin
                sh_reg = {reg_q[REG_LENGTH-1], reg_q[REG_LENGTH-1:1]};
                sh_so  = reg_q[0];
            end
            M_ROL: begin
                sh_reg = {reg_q[REG_LENGTH-2:0], reg_q[REG_LENGTH-1]};
                sh_so  = reg_q[REG_LENGTH-1];
            end
            M_ROR: begin
                sh_reg = {reg_q[0], reg_q[REG_LENGTH-1:1]};
                sh_so  = reg_q[0];
            end
            M_SHL_S: begin
                sh_reg = {reg_q[REG_LENGTH-2:0], serialIn};
                sh_so  = reg_q[REG_LENGTH-1];
            end
            M_SHR_S: begin
                sh_reg = {serialIn, reg_q[REG_LENGTH-1:1]};
                sh_so  = reg_q[0];
            end
            default: begin
                sh_reg = reg_q;
                sh_so  = so_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (load) begin
            reg_d   = load_val;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start && state_q == ST_IDLE) begin
            if (count == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                cnt_d   = count;
                mode_d  = mode;
            end
        end else if (state_q == ST_RUN) begin
            reg_d = sh_reg;
            so_d  = sh_so;
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (shift) begin
            reg_d = sh_reg;
            so_d  = sh_so;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            so_q    <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            so_q    <= so_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign parallelOutput = reg_q;
    assign serialOut      = so_q;
    assign busy           = (state_q == ST_RUN);
    assign done           = done_q;

endmodule

// File: tb/tb_pipo_universal_shifter.sv
// Bench for pipo_universal_shifter: directed scenarios plus random traffic,
// all checked every cycle against an arithmetic reference model.
module tb_pipo_universal_shifter;

    logic        clk = 1'b0;
    logic        rst, load, signExt, shift, start, serialIn;
    logic [7:0]  parallelInput;
    logic [2:0]  mode;
    logic [4:0]  count;
    logic [15:0] parallelOutput;
    logic        serialOut, busy, done;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    pipo_universal_shifter #(.WORD_LENGTH(8), .REG_LENGTH(16), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .load(load), .signExt(signExt),
        .parallelInput(parallelInput), .mode(mode), .shift(shift),
        .start(start), .count(count), .serialIn(serialIn),
        .parallelOutput(parallelOutput), .serialOut(serialOut),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: register held as an integer 0..65535.
    int m_r = 0;
    int m_so = 0;
    int m_busy = 0;
    int m_done = 0;
    int m_rem = 0;
    int m_mode = 0;

    function automatic void step(input int md, input int sin, inout int r, inout int so);
        int msb, lsb;
        msb = r / 32768;
        lsb = r % 2;
        case (md)
            0: begin r = (r * 2) % 65536;              so = msb; end
            1: begin r = r / 2;                        so = lsb; end
            2: begin r = r / 2 + msb * 32768;          so = lsb; end
            3: begin r = (r * 2) % 65536 + msb;        so = msb; end
            4: begin r = r / 2 + lsb * 32768;          so = lsb; end
            5: begin r = (r * 2) % 65536 + sin;        so = msb; end
            6: begin r = r / 2 + sin * 32768;          so = lsb; end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_r = 0; m_so = 0; m_busy = 0; m_rem = 0; m_mode = 0;
        end else if (load) begin
            m_r = int'(parallelInput);
            if (signExt && parallelInput >= 8'h80) m_r = m_r + 16'hFF00;
            m_busy = 0;
        end else if (start && m_busy == 0) begin
            if (count == 0) m_done = 1;
            else begin
                m_busy = 1; m_rem = int'(count); m_mode = int'(mode);
            end
        end else if (m_busy != 0) begin
            step(m_mode, int'(serialIn), m_r, m_so);
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 0; m_done = 1;
            end
        end else if (shift) begin
            step(int'(mode), int'(serialIn), m_r, m_so);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_out",  int'(parallelOutput), m_r);
            chk("model_so",   int'(serialOut),      m_so);
            chk("model_busy", int'(busy),           m_busy);
            chk("model_done", int'(done),           m_done);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; load = 0; signExt = 0; shift = 0; start = 0;
        serialIn = 0; parallelInput = 0; mode = 3'd7; count = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        armed = 1'b1;
        chk("reset_out", int'(parallelOutput), 16'h0000);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 0;

        load = 1; parallelInput = 8'hA5; signExt = 0; tick();
        chk("load_zext", int'(parallelOutput), 16'h00A5);
        signExt = 1; tick();
        chk("load_sext", int'(parallelOutput), 16'hFFA5);

        parallelInput = 8'h81; signExt = 0; tick();
        load = 0; shift = 1; mode = 3'd0;
        repeat (3) tick();
        chk("shl3", int'(parallelOutput), 16'h0408);
        mode = 3'd2; tick();
        chk("sar1", int'(parallelOutput), 16'h0204);
        chk("sar1_so", int'(serialOut), 0);
        shift = 0;

        load = 1; parallelInput = 8'hF0; signExt = 1; tick();
        load = 0; start = 1; count = 5'd4; mode = 3'd2; tick();
        start = 0; mode = 3'd0;
        chk("run_busy0", int'(busy), 1);
        chk("run_out0", int'(parallelOutput), 16'hFFF0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("run_busy_mid", int'(busy), 1);
            chk("run_done_mid", int'(done), 0);
        end
        tick();
        chk("run_done", int'(done), 1);
        chk("run_busy_end", int'(busy), 0);
        chk("run_result", int'(parallelOutput), 16'hFFFF);
        tick();
        chk("run_done_once", int'(done), 0);

        load = 1; parallelInput = 8'h01; signExt = 0; tick();
        load = 0; start = 1; count = 5'd1; mode = 3'd4; tick();
        start = 0; tick();
        chk("ror_out", int'(parallelOutput), 16'h8000);
        chk("ror_so", int'(serialOut), 1);
        mode = 3'd5; serialIn = 1; shift = 1;
        repeat (2) tick();
        chk("shls_out", int'(parallelOutput), 16'h0003);
        chk("shls_so", int'(serialOut), 0);
        shift = 0; serialIn = 0;

        load = 1; parallelInput = 8'h12; tick();
        load = 0; start = 1; count = 5'd10; mode = 3'd0; tick();
        start = 1; shift = 1; count = 5'd2; mode = 3'd1; tick();
        chk("ignore_busy", int'(busy), 1);
        chk("ignore_out", int'(parallelOutput), 16'h0024);
        start = 0; shift = 0; tick();
        load = 1; parallelInput = 8'h55; tick();
        load = 0;
        chk("abort_out", int'(parallelOutput), 16'h0055);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        tick();
        chk("abort_no_done", int'(done), 0);

        start = 1; count = 5'd0; tick();
        start = 0;
        chk("cnt0_done", int'(done), 1);
        chk("cnt0_out", int'(parallelOutput), 16'h0055);
        chk("cnt0_busy", int'(busy), 0);
        tick();
        chk("cnt0_done_once", int'(done), 0);

        start = 1; count = 5'd2; mode = 3'd3; tick();
        start = 0; repeat (2) tick();
        chk("b2b_done", int'(done), 1);
        start = 1; count = 5'd3; tick();
        start = 0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_done_once", int'(done), 0);
        repeat (3) tick();

        start = 1; count = 5'd8; mode = 3'd3; tick();
        start = 0; repeat (2) tick();
        rst = 1; tick();
        rst = 0;
        chk("midrst_out", int'(parallelOutput), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_so", int'(serialOut), 0);
        chk("midrst_done", int'(done), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_done", int'(done), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            load          = ($urandom_range(0, 15) == 0);
            signExt       = $urandom_range(0, 1);
            parallelInput = 8'($urandom);
            mode          = 3'($urandom);
            shift         = $urandom_range(0, 1);
            start         = ($urandom_range(0, 7) == 0);
            count         = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            serialIn      = $urandom_range(0, 1);
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
